// File: rtl/wb_client_ram.sv
// Byte-writable word RAM behind the Wishbone client request/response streams.
// Optional WB_CLIENT_RAM_RANGE_CHECK_EN rejects misaligned/out-of-range addresses.
module wb_client_ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RDY_client_request_get,
  input  logic [68:0] client_request_get,
  output logic        EN_client_request_get,
  input  logic        RDY_client_response_put,
  output logic        EN_client_response_put,
  output logic [31:0] client_response_put,
  output logic [7:0]  err_count
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [31:0] BAD_DATA = 32'hBADADD00;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t                  req;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req_bad;
  logic                  accept, push, pop;
  logic [CW-1:0]         occ, cnt;
  logic [PW-1:0]         rd_ptr, wr_ptr;

  assign req = client_request_get;
  assign idx = req.adr[ADDR_WIDTH+1:2];

`ifdef WB_CLIENT_RAM_RANGE_CHECK_EN
  assign req_bad = (|req.adr[31:ADDR_WIDTH+2]) | (|req.adr[1:0]);
`else
  logic unused_adr;
  assign req_bad    = 1'b0;
  assign unused_adr = ^{req.adr[31:ADDR_WIDTH+2], req.adr[1:0]};
`endif

  // Credits count everything between accept and pop, so the FIFO can never overflow.
  assign accept = RST_N & RDY_client_request_get & (occ < CW'(RESP_DEPTH));
  assign EN_client_request_get = accept;

  logic [31:0]                   mem [2**ADDR_WIDTH];
  logic [READ_LATENCY:1][31:0]   raw_pipe;
  logic [READ_LATENCY:1]         vld_pipe, we_pipe, bad_pipe;
  logic [31:0]                   pipe_dat;

  always_ff @(posedge CLK) begin
    if (accept && req.we && !req_bad)
      for (int i = 0; i < 4; i++)
        if (req.sel[i]) mem[idx][8*i +: 8] <= req.dat[8*i +: 8];
    raw_pipe[1] <= mem[idx];
    for (int k = 2; k <= READ_LATENCY; k++) raw_pipe[k] <= raw_pipe[k-1];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
      bad_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      we_pipe[1]  <= req.we;
      bad_pipe[1] <= req_bad;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        we_pipe[k]  <= we_pipe[k-1];
        bad_pipe[k] <= bad_pipe[k-1];
      end
    end
  end

  assign pipe_dat = we_pipe[READ_LATENCY]  ? 32'h0 :
                    bad_pipe[READ_LATENCY] ? BAD_DATA : raw_pipe[READ_LATENCY];

  // Response FIFO
  logic [31:0] fifo_mem [RESP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = vld_pipe[READ_LATENCY];
  assign pop  = RDY_client_response_put & (cnt != '0);
  assign EN_client_response_put = pop;
  assign client_response_put    = (cnt != '0) ? fifo_mem[rd_ptr] : 32'h0;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= pipe_dat;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
      occ <= occ + CW'(accept) - CW'(pop);
    end
  end

`ifdef WB_CLIENT_RAM_RANGE_CHECK_EN
  logic [7:0] err_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                   err_q <= '0;
    else if (accept && req_bad && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = 8'h0;
`endif

endmodule

// File: tb/tb_wb_client_ram.sv
// Randomized scoreboard bench for wb_client_ram against an array-based reference model.
module tb_wb_client_ram;
  localparam int AW = 8;
  localparam int RL = 2;
  localparam int RD = 4;
`ifdef WB_CLIENT_RAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RDY_req;
  logic [68:0] req_w;
  logic        RDY_put;
  logic        EN_req, EN_resp;
  logic [31:0] resp;
  logic [7:0]  err;

  wb_client_ram #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .RESP_DEPTH(RD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RDY_client_request_get(RDY_req), .client_request_get(req_w),
    .EN_client_request_get(EN_req),
    .RDY_client_response_put(RDY_put), .EN_client_response_put(EN_resp),
    .client_response_put(resp), .err_count(err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] dat; int acc; } exp_t;
  exp_t        sbq[$];
  logic [31:0] mdl [2**AW];
  int          checks = 0, errors = 0;
  int          cyc = 0, last_pop = -100, last_acc = 0, err_m = 0;
  bit          lat_chk = 1'b0, rnd_put = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) if (rnd_put) RDY_put = ($urandom_range(0, 3) != 0);

  // Monitor: every response the DUT presents must match the next queued expectation.
  exp_t mon_e;
  int   mon_exp_c;
  always @(negedge CLK) begin
    #2;
    if (EN_resp) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL stale_resp: got response %h with nothing outstanding, required no response", resp);
      end else begin
        mon_e = sbq.pop_front();
        if (resp !== mon_e.dat) begin
          errors++;
          $display("FAIL resp_data: got %h required %h (accepted cycle %0d)", resp, mon_e.dat, mon_e.acc);
        end
        if (lat_chk) begin
          mon_exp_c = (mon_e.acc + RL + 1 > last_pop + 1) ? mon_e.acc + RL + 1 : last_pop + 1;
          checks++;
          if (cyc != mon_exp_c) begin
            errors++;
            $display("FAIL resp_cycle: got cycle %0d required %0d", cyc, mon_exp_c);
          end
        end
      end
      last_pop = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: applies the request rules and queues the expected response.
  task automatic model_accept(input logic [68:0] r);
    bit          we  = r[68];
    logic [3:0]  sel = r[67:64];
    logic [31:0] adr = r[63:32];
    logic [31:0] dat = r[31:0];
    int          w   = int'(adr[AW+1:2]);
    bit          bad = RC && ((adr >> (AW + 2)) != 0 || adr[1:0] != 2'b00);
    exp_t        e;
    e.acc = cyc;
    if (we) begin
      if (!bad)
        for (int i = 0; i < 4; i++) if (sel[i]) mdl[w][8*i +: 8] = dat[8*i +: 8];
      e.dat = 32'h0;
    end else begin
      e.dat = bad ? 32'hBADADD00 : mdl[w];
    end
    if (bad && err_m < 255) err_m++;
    last_acc = cyc;
    sbq.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    int n = 0;
    @(negedge CLK);
    RDY_req = 1'b1;
    req_w   = {we, sel, adr, dat};
    #1;
    while (!EN_req && n < 200) begin
      @(negedge CLK); #1; n++;
    end
    if (!EN_req) begin
      checks++; errors++;
      $display("FAIL accept_timeout: EN_client_request_get stayed 0, required 1 within 200 cycles");
      RDY_req = 1'b0;
      return;
    end
    model_accept(req_w);
    @(posedge CLK); #1;
    RDY_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge CLK); n++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  function automatic logic [31:0] wadr(input int w);
    return 32'(w) << 2;
  endfunction

  initial begin
    int n_acc, first_acc;
    logic [31:0] a;
    RST_N = 1'b0; RDY_req = 1'b1; RDY_put = 1'b1; req_w = {1'b1, 4'hF, 64'h0};
    #1;
    chk("reset_en_req", 32'(EN_req), 32'h0);
    chk("reset_en_resp", 32'(EN_resp), 32'h0);
    chk("reset_resp", resp, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1; RDY_req = 1'b0;
    lat_chk = 1'b1;

    // Write then read-back on the next cycle, exact latency.
    issue(1'b1, 4'hF, 32'h10, 32'hA5A5_1234);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    drain();

    for (int w = 0; w < 2**AW; w++) if (w != 4) issue(1'b1, 4'hF, wadr(w), $urandom);
    drain();

    // Partial byte enables and sel=0.
    issue(1'b1, 4'hF, 32'h20, 32'hFFFF_FFFF);
    issue(1'b1, 4'h5, 32'h20, 32'h1122_3344);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    issue(1'b1, 4'h0, 32'h20, 32'h0);
    issue(1'b0, 4'hA, 32'h20, 32'h0);
    drain();

    // Response side stalled: credits cap acceptance.
    lat_chk = 1'b0; RDY_put = 1'b0; n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      RDY_req = 1'b1; req_w = {1'b0, 4'h0, wadr($urandom_range(0, 255)), 32'h0};
      #1;
      if (EN_req) begin model_accept(req_w); n_acc++; end
    end
    chk("stall_accepts", 32'(n_acc), 32'(RD));
    chk("stall_en_req", 32'(EN_req), 32'h0);
    for (int c = 0; c < 40 && n_acc < 8; c++) begin
      @(negedge CLK);
      RDY_put = 1'b1; RDY_req = 1'b1; req_w = {1'b0, 4'h0, wadr($urandom_range(0, 255)), 32'h0};
      #1;
      if (EN_req) begin model_accept(req_w); n_acc++; end
    end
    @(posedge CLK); #1 RDY_req = 1'b0;
    chk("stall_resume_accepts", 32'(n_acc), 32'd8);
    drain();

    // Sustained reads: one accept and one response per cycle.
    lat_chk = 1'b1;
    first_acc = -1;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 4'h0, wadr($urandom_range(0, 255)), 32'h0);
      if (first_acc < 0) first_acc = last_acc;
    end
    chk("sustained_span", 32'(last_acc - first_acc), 32'd15);
    drain();

    // Asynchronous reset with requests in flight.
    lat_chk = 1'b0; RDY_put = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 4'h0, wadr(i), 32'h0);
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    RDY_put = 1'b1; RDY_req = 1'b1; req_w = {1'b0, 4'h0, wadr(7), 32'h0};
    #1;
    chk("pre_rst_en_resp", 32'(EN_resp), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_en_req", 32'(EN_req), 32'h0);
    chk("rst_en_resp", 32'(EN_resp), 32'h0);
    chk("rst_resp", resp, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    sbq.delete(); err_m = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("post_rst_accept", 32'(EN_req), 32'h1);
    if (EN_req) model_accept(req_w);
    @(posedge CLK); #1 RDY_req = 1'b0;
    repeat (6) @(negedge CLK);
    drain();

    // Misaligned address: rejected with the range check, aliases to word 0 without it.
    lat_chk = 1'b1;
    issue(1'b0, 4'h0, 32'h0000_0402, 32'h0);
    drain();
    chk("err_count_one", 32'(err), 32'(err_m));
    issue(1'b1, 4'hF, 32'h0000_0402, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0);
    drain();

    // Random traffic with random response back-pressure.
    lat_chk = 1'b0; rnd_put = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : wadr($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
      issue($urandom_range(0, 1) == 1, 4'($urandom), a, $urandom);
    end
    rnd_put = 1'b0; RDY_put = 1'b1;
    drain();
    chk("err_count_final", 32'(err), 32'(err_m));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_client_ram.md
# wb_client_ram

Word-addressed, byte-writable RAM target that sits directly downstream of the 32-bit Wishbone slave transactor. It consumes the transactor's client request stream, performs the read or write, and returns exactly one 32-bit response per request on the client response stream. Reads go through a fixed-latency pipeline, and responses are buffered. The block never issues more requests than it can buffer responses for, so the transactor's ACK stream can stall on the response side without losing data.

## Interface
- ADDR_WIDTH, 8: word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2: read pipeline register stages; legal range 1..4.
- RESP_DEPTH, 4: response FIFO entries and in-flight credit limit; legal range 2..16.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- RDY_client_request_get  in  1  transactor has a request available.
- client_request_get  in  69  request word: [68] we, [67:64] sel, [63:32] adr (byte address), [31:0] write data.
- EN_client_request_get  out  1  dequeue request this cycle.
- RDY_client_response_put  in  1  transactor can take a response.
- EN_client_response_put  out  1  enqueue response this cycle.
- client_response_put  out  32  response data.
- err_count  out  8  saturating count of rejected requests (see Configuration).

## Operation
- Word index = adr[ADDR_WIDTH+1:2]. Without the macro, adr[31:ADDR_WIDTH+2] and adr[1:0] are ignored, so addresses alias.
- Credit counter `occ` (0..RESP_DEPTH) tracks requests accepted but whose response has not yet been enqueued to the transactor.
- EN_client_request_get = RDY_client_request_get && occ < RESP_DEPTH. Credits freed by a response in the same cycle are not reused until the next cycle.
- occ_next = occ + accept − pop. Simultaneous accept and pop leaves occ unchanged.
- Write (we=1): for each i with sel[i]=1, byte i of the addressed word ← dat[8i+7:8i]. sel=0 modifies nothing. The response data is 32'h0.
- Read (we=0): the addressed word is read synchronously and carried through the READ_LATENCY valid/data stages. sel is ignored.
- Writes and reads share one ordered pipeline. Responses leave in request order.
- The pipeline output is pushed into the response FIFO, which always has room because of the credit rule. A FIFO overflow is a design error.
- EN_client_response_put = RDY_client_response_put && FIFO non-empty. client_response_put = FIFO head, or 32'h0 when empty.
- RAM contents are not reset.
- Reset, asynchronous and possibly mid-operation, clears pipeline valids, the FIFO, occ and err_count, and drives all outputs to 0 immediately. In-flight requests are dropped; the transactor shares RST_N.

## Timing
- A write accepted in cycle T is committed at the end of T.
- A read accepted at T+1 to the same word returns the new data. There is no read-during-write hazard because commit precedes the next accept.
- With an empty FIFO and RDY_client_response_put high, a request accepted in cycle T produces EN_client_response_put in cycle T+READ_LATENCY+1. Writes have the same latency.
- Throughput is 1 request/cycle sustained if RESP_DEPTH ≥ READ_LATENCY+2. Otherwise it is bounded by credits.
- If RDY_client_response_put stays low, at most RESP_DEPTH requests are accepted. EN_client_request_get then stays low until a pop.
- Reset values: EN_client_request_get=0, EN_client_response_put=0, client_response_put=0, err_count=0.

## Configuration
- Macro: WB_CLIENT_RAM_RANGE_CHECK_EN.
- Defined: a request is rejected if adr[31:ADDR_WIDTH+2] ≠ 0 or adr[1:0] ≠ 0.
  - A rejected write modifies nothing.
  - A rejected read returns 32'hBADADD00.
  - Rejected requests still produce one response each at normal latency.
  - err_count increments by 1 per rejected request, saturating at 8'hFF.
- Undefined: there is no range check, addresses alias, and err_count is tied to 0.

## Test plan
- Reset, then write adr=0x10, sel=4'hF, dat=0xA5A5_1234 at T, then read adr=0x10 at T+1. Expected: write response 0x0 at T+READ_LATENCY+1, then read response 0xA5A5_1234 the next cycle.
- Word 0x20 holds 0xFFFF_FFFF; write sel=4'b0101, dat=0x1122_3344; read back. Expected: 0xFF22_FF44.
- Hold RDY_client_response_put low and offer 8 back-to-back reads. Expected: exactly RESP_DEPTH=4 accepted and EN_client_request_get low thereafter. Raise RDY: 4 responses come out in order, then acceptance resumes.
- Sustained 16 reads with RESP_DEPTH=4, READ_LATENCY=2, RDY held high. Expected: one response per cycle with no gaps after the first.
- Assert RST_N low mid-burst with 3 requests in flight. Expected: all ENs drop asynchronously, no stale response after release, and the first post-reset request is accepted in the first cycle RDY is high.
- With the macro defined: read adr=0x0000_0402 with ADDR_WIDTH=8. Expected: response 0xBADADD00 and err_count=1. A write to the same address leaves RAM unchanged.
